// File: rtl/mips_cpu_arb_pkg.sv
// mips_cpu_arb_pkg: shared state, source encodings and constants for the CPU memory arbiter.
package mips_cpu_arb_pkg;
    typedef enum logic [1:0] {IDLE = 2'b00, INSTR = 2'b01, DATA = 2'b10} arb_state_t;
    typedef enum logic {SRC_INSTR = 1'b0, SRC_DATA = 1'b1} arb_src_t;
    localparam logic [3:0] BE_ALL = 4'b1111;
endpackage

// File: rtl/mips_cpu_arb_rr.sv
// mips_cpu_arb_rr: two-way grant selection, fixed data priority or round-robin against rr_last.
module mips_cpu_arb_rr
    import mips_cpu_arb_pkg::*;
#(
    parameter int FIXED_PRIO = 0
) (
    input  logic     instr_elig,
    input  logic     data_elig,
    input  arb_src_t rr_last,
    output logic     grant_valid,
    output arb_src_t grant
);
    assign grant_valid = instr_elig | data_elig;
    assign grant = (instr_elig && data_elig)
                 ? ((FIXED_PRIO != 0 || rr_last == SRC_INSTR) ? SRC_DATA : SRC_INSTR)
                 : (data_elig ? SRC_DATA : SRC_INSTR);
endmodule

// File: rtl/mips_cpu_mem_arbiter.sv
// mips_cpu_mem_arbiter: shares one Avalon bus between the fetch and data ports of the CPU.
// Defining MIPS_ARB_PERF_CNT_EN adds the perf_stall_cycles / perf_bus_busy counters.
module mips_cpu_mem_arbiter
    import mips_cpu_arb_pkg::*;
#(
    parameter int FIXED_PRIO = 0,
    parameter int ADDR_W     = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              instr_req,
    input  logic [ADDR_W-1:0] instr_address,
    output logic [31:0]       instr_readdata,
    output logic              instr_valid,
    input  logic              data_read,
    input  logic              data_write,
    input  logic [ADDR_W-1:0] data_address,
    input  logic [31:0]       data_writedata,
    input  logic [3:0]        data_byteenable,
    output logic [31:0]       data_readdata,
    output logic              data_valid,
    output logic [ADDR_W-1:0] address,
    output logic              read,
    output logic              write,
    output logic [3:0]        byteenable,
    output logic [31:0]       writedata,
    input  logic              waitrequest,
    input  logic [31:0]       readdata,
    output logic              cpu_stall
`ifdef MIPS_ARB_PERF_CNT_EN
    ,
    output logic [31:0]       perf_stall_cycles,
    output logic [31:0]       perf_bus_busy
`endif
);
    arb_state_t state;
    arb_src_t   rr_last, grant;
    logic       grant_valid, instr_elig, data_elig;

    // A requester whose valid is high this cycle is finishing, not asking again.
    assign instr_elig = instr_req & ~instr_valid;
    assign data_elig  = (data_read | data_write) & ~data_valid;
    assign cpu_stall  = instr_elig | data_elig;

    mips_cpu_arb_rr #(.FIXED_PRIO(FIXED_PRIO)) u_rr (
        .instr_elig (instr_elig),
        .data_elig  (data_elig),
        .rr_last    (rr_last),
        .grant_valid(grant_valid),
        .grant      (grant)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            rr_last        <= SRC_DATA;
            read           <= 1'b0;
            write          <= 1'b0;
            instr_valid    <= 1'b0;
            data_valid     <= 1'b0;
            address        <= '0;
            writedata      <= '0;
            byteenable     <= '0;
            instr_readdata <= '0;
            data_readdata  <= '0;
        end else begin
            instr_valid <= 1'b0;
            data_valid  <= 1'b0;
            if (state == IDLE) begin
                if (grant_valid) begin
                    rr_last <= grant;
                    if (grant == SRC_INSTR) begin
                        state      <= INSTR;
                        address    <= instr_address;
                        byteenable <= BE_ALL;
                        writedata  <= '0;
                        read       <= 1'b1;
                    end else begin
                        state      <= DATA;
                        address    <= data_address;
                        byteenable <= data_byteenable;
                        writedata  <= data_writedata;
                        read       <= data_read;
                        write      <= data_write;
                    end
                end
            end else if (!waitrequest) begin
                state <= IDLE;
                read  <= 1'b0;
                write <= 1'b0;
                if (state == INSTR) begin
                    instr_valid    <= 1'b1;
                    instr_readdata <= readdata;
                end else begin
                    data_valid <= 1'b1;
                    if (read) data_readdata <= readdata;
                end
            end
        end
    end

`ifdef MIPS_ARB_PERF_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_stall_cycles <= '0;
            perf_bus_busy     <= '0;
        end else begin
            if (cpu_stall) perf_stall_cycles <= perf_stall_cycles + 32'd1;
            if (read | write) perf_bus_busy <= perf_bus_busy + 32'd1;
        end
    end
`endif
endmodule
